ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single unified RAM port between two requesters.
//  - Requester 0 (CPU): the multicycle datapath (fetch/load/store).
//  - Requester 1 (DBG): the program-loader/debug port.
//  - Serialises accesses, enforces RAM read latency, returns read data with a done pulse.
//  - Drives cpu_stall so the control unit holds pc_write/ir_write until its access completes.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  RD_LAT    1   RAM read latency in cycles, legal 1..4
//  MAX_WAIT  8   DBG starvation limit in cycles; at this count DBG beats CPU
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-low reset
//  cpu_req    in   1   CPU access request, held until cpu_done
//  cpu_we     in   1   1=write 0=read, stable while cpu_req
//  cpu_addr   in   AW  CPU address, stable while cpu_req
//  cpu_wdata  in   DW  CPU write data, stable while cpu_req
//  cpu_done   out  1   one-cycle completion pulse to CPU
//  cpu_stall  out  1   1 while a CPU request is pending and not yet done
//  dbg_req    in   1   DBG access request, held until dbg_done
//  dbg_we     in   1   1=write 0=read
//  dbg_addr   in   AW  DBG address
//  dbg_wdata  in   DW  DBG write data
//  dbg_done   out  1   one-cycle completion pulse to DBG
//  rdata      out  DW  read data; valid only in the done cycle, holds value otherwise
//  ram_addr   out  AW  RAM address (registered)
//  ram_wdata  out  DW  RAM write data (registered)
//  ram_we     out  1   RAM write strobe, exactly one cycle per write
//  ram_rdata  in   DW  RAM read data, valid RD_LAT cycles after ram_addr is presented
// BEHAVIOUR
//  Reset (reset==0 at a rising edge):
//  - State = IDLE; owner = CPU; lat_cnt = 0; wait_cnt = 0.
//  - All outputs 0, except cpu_stall, which follows cpu_req combinationally.
//  - Reset mid-access aborts the access: no done pulse; ram_we = 0 from the next edge.
//  FSM states IDLE, ACCESS, RESP.
//  - IDLE: sample requests and pick a winner.
//    - Only one request -> that requester wins.
//    - Both requests -> CPU wins, unless wait_cnt == MAX_WAIT, then DBG wins.
//    - On grant: latch owner, we, addr, wdata into ram_* registers; go to ACCESS.
//  - ACCESS, write: ram_we = 1 for this single cycle; go to RESP.
//  - ACCESS, read: ram_we = 0; stay RD_LAT cycles (lat_cnt counts 0..RD_LAT-1).
//    - Capture ram_rdata into rdata at the last edge; go to RESP.
//  - RESP: pulse owner's done for one cycle; ram_we = 0; go to IDLE.
//  - No back-to-back grant out of RESP.
//  Latency (request seen in IDLE cycle 0):
//  - Write: ACCESS in cycle 1, done in cycle 2.
//  - Read: done in cycle RD_LAT+1.
//  - Minimum spacing is 3 cycles per access.
//  Handshake rules:
//  - The requester drops req in the cycle after done.
//  - req still high in IDLE after done is treated as a new request.
//  - A req that drops before its grant is ignored, with no side effects.
//  - Inputs change while owned: ignored (latched copy used).
//  wait_cnt:
//  - +1 per cycle while dbg_req==1 and DBG is not owner; saturates at MAX_WAIT.
//  - Cleared to 0 on DBG grant or when dbg_req==0.
//  cpu_stall = cpu_req & ~cpu_done (combinational).
//  At most one of cpu_done/dbg_done is high in any cycle.
//  ram_we is never high outside ACCESS.
// STRUCTURE
//  Shared include mem_arb_defs.vh holds:
//  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2 (2'd3 -> IDLE).
//  - owner codes OWN_CPU=1'b0, OWN_DBG=1'b1.
//  One sub-module, sat_counter (width = clog2(MAX_WAIT+1), inc/clr/sat): the starvation counter.
//  FSM, latency counter and ram_* registers live in ram_port_arbiter.
// TESTING
//  - CPU read: addr=0x10, RAM[0x10]=0xDEADBEEF, RD_LAT=1 -> cpu_done in cycle 2, rdata=0xDEADBEEF, ram_we never 1.
//  - DBG write: addr=0x20, wdata=0x12345678 -> ram_we one cycle (cycle 1), ram_addr=0x20; dbg_done in cycle 2.
//  - Contention: both req continuously, MAX_WAIT=8 -> CPU wins until wait_cnt=8, then DBG granted; counter clears; no double done.
//  - RD_LAT=3 CPU read while dbg_req rises mid-access -> DBG waits; cpu_done in cycle 4; DBG granted in next IDLE.
//  - Reset low during ACCESS of a write -> ram_we=0 and no done after the edge; state IDLE; clean access after release.
//  - req held high after done -> a second full access occurs; req pulsed 1 cycle while other owner busy -> ignored.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM encodings, owner codes and sizing helper for the RAM port arbiter
package ram_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/ram_port_arbiter_sat_counter.sv
// ram_port_arbiter_sat_counter: saturating up-counter with clear priority, flags when it reaches MAX
module ram_port_arbiter_sat_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   logic [W-1:0] cnt;
   assign sat = cnt == W'(MAX);
   // clear wins over increment; count holds once saturated
   always_ff @(posedge clk) begin
      if (!reset || clr) cnt <= '0;
      else if (inc && !sat) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises CPU and debug-port accesses onto one RAM port with fixed read latency
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_done,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_done,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);
   localparam int CW = cnt_width(MAX_WAIT);
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
   state_t     state;
   logic       owner;
   logic [1:0] lat_cnt;
   logic       wait_sat;
   logic       dbg_busy;
   logic       grant_cpu;
   logic       grant_dbg;
   // DBG beats CPU only once it has starved for MAX_WAIT cycles
   always_comb begin
      dbg_busy  = state != ST_IDLE && owner == OWN_DBG;
      grant_dbg = state == ST_IDLE && dbg_req && (!cpu_req || wait_sat);
      grant_cpu = state == ST_IDLE && cpu_req && !grant_dbg;
   end
   assign cpu_stall = cpu_req & ~cpu_done;
   ram_port_arbiter_sat_counter #(.W(CW), .MAX(MAX_WAIT)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (dbg_req & ~dbg_busy),
      .clr   (~dbg_req | grant_dbg),
      .sat   (wait_sat)
   );
   // grant latches the winner's request; a write strobes for its one ACCESS cycle, a read waits RD_LAT cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         owner     <= OWN_CPU;
         lat_cnt   <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         rdata     <= '0;
         cpu_done  <= 1'b0;
         dbg_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (grant_cpu || grant_dbg) begin
               state     <= ST_ACCESS;
               owner     <= grant_dbg ? OWN_DBG : OWN_CPU;
               ram_we    <= grant_dbg ? dbg_we : cpu_we;
               ram_addr  <= grant_dbg ? dbg_addr : cpu_addr;
               ram_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            ST_ACCESS: if (ram_we || lat_cnt == LAT_LAST) begin
               state    <= ST_RESP;
               ram_we   <= 1'b0;
               lat_cnt  <= '0;
               rdata    <= ram_we ? rdata : ram_rdata;
               cpu_done <= owner == OWN_CPU;
               dbg_done <= owner == OWN_DBG;
            end else begin
               lat_cnt <= lat_cnt + 2'd1;
            end
            ST_RESP: begin
               state    <= ST_IDLE;
               cpu_done <= 1'b0;
               dbg_done <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of arbitration, latency, handshake and reset behaviour
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_done, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        dbg_req, dbg_we, dbg_done;
   logic [31:0] dbg_addr, dbg_wdata;
   logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
   logic        ram_we;
   logic        l3_cpu_req, l3_cpu_we, l3_cpu_done, l3_cpu_stall;
   logic [31:0] l3_cpu_addr, l3_cpu_wdata;
   logic        l3_dbg_req, l3_dbg_we, l3_dbg_done;
   logic [31:0] l3_dbg_addr, l3_dbg_wdata;
   logic [31:0] l3_rdata, l3_ram_addr, l3_ram_wdata, l3_ram_rdata;
   logic        l3_ram_we;
   logic [31:0] mem [256];
   logic [31:0] p1, p2;
   int errors = 0;
   int checks = 0;

   ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(8)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_done(dbg_done), .rdata(rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(8)) u_dut3 (
      .clk(clk), .reset(reset),
      .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
      .cpu_done(l3_cpu_done), .cpu_stall(l3_cpu_stall),
      .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
      .dbg_done(l3_dbg_done), .rdata(l3_rdata),
      .ram_addr(l3_ram_addr), .ram_wdata(l3_ram_wdata), .ram_we(l3_ram_we), .ram_rdata(l3_ram_rdata)
   );

   assign ram_rdata = mem[ram_addr[7:0]];
   always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
   always @(posedge clk) begin
      p1 <= mem[l3_ram_addr[7:0]];
      p2 <= p1;
   end
   assign l3_ram_rdata = p2;

   task automatic cyc;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      cyc; cyc;
      checks++;
      if ({cpu_done, dbg_done, ram_we, ram_addr, ram_wdata, rdata} !== '0) begin
         errors++; $display("FAIL reset_outs: got %h expected 0", {cpu_done, dbg_done, ram_we, ram_addr, ram_wdata, rdata});
      end
      checks++;
      if ({l3_cpu_done, l3_dbg_done, l3_ram_we, l3_ram_addr, l3_ram_wdata, l3_rdata} !== '0) begin
         errors++; $display("FAIL reset_outs_l3: got %h expected 0", {l3_cpu_done, l3_dbg_done, l3_ram_we, l3_ram_addr, l3_ram_wdata, l3_rdata});
      end
      cpu_req = 1'b1; #1;
      checks++;
      if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi: got %b expected 1", cpu_stall); end
      cpu_req = 1'b0; #1;
      checks++;
      if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b expected 0", cpu_stall); end
      cyc;
      reset = 1'b1;
   endtask

   task automatic test_cpu_read;
      cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc;
         checks++;
         if (cpu_done !== (k == 2)) begin errors++; $display("FAIL cpu_read_done[%0d]: got %b expected %b", k, cpu_done, k == 2); end
         checks++;
         if (ram_we !== 1'b0) begin errors++; $display("FAIL cpu_read_we[%0d]: got %b expected 0", k, ram_we); end
         if (k < 3) begin
            checks++;
            if (cpu_stall !== (k == 1)) begin errors++; $display("FAIL cpu_read_stall[%0d]: got %b expected %b", k, cpu_stall, k == 1); end
         end
         if (k == 1) begin
            checks++;
            if (ram_addr !== 32'h10) begin errors++; $display("FAIL cpu_read_addr: got %h expected 00000010", ram_addr); end
         end
         if (k == 2) begin
            checks++;
            if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_data: got %h expected deadbeef", rdata); end
         end
         if (k == 3) cpu_req = 1'b0;
      end
   endtask

   task automatic test_dbg_write;
      dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc;
         checks++;
         if (ram_we !== (k == 1)) begin errors++; $display("FAIL dbg_write_we[%0d]: got %b expected %b", k, ram_we, k == 1); end
         checks++;
         if ({cpu_done, dbg_done} !== {1'b0, k == 2}) begin errors++; $display("FAIL dbg_write_done[%0d]: got %b expected %b", k, {cpu_done, dbg_done}, {1'b0, k == 2}); end
         if (k == 1) begin
            checks++;
            if ({ram_addr, ram_wdata} !== {32'h20, 32'h12345678}) begin errors++; $display("FAIL dbg_write_bus: got %h expected 0000002012345678", {ram_addr, ram_wdata}); end
         end
         if (k == 2) begin
            checks++;
            if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dbg_write_rdata_hold: got %h expected deadbeef", rdata); end
         end
         if (k == 3) dbg_req = 1'b0;
         if (k == 4) begin
            checks++;
            if (mem[8'h20] !== 32'h12345678) begin errors++; $display("FAIL dbg_write_mem: got %h expected 12345678", mem[8'h20]); end
         end
      end
   endtask

   task automatic test_contention;
      cpu_we = 1'b0; cpu_addr = 32'h10; dbg_we = 1'b0; dbg_addr = 32'h20;
      cpu_req = 1'b1; dbg_req = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         cyc;
         checks++;
         if ({cpu_done, dbg_done} !== {k == 2 || k == 5 || k == 8, k == 11}) begin
            errors++; $display("FAIL contention_done[%0d]: got %b expected %b", k, {cpu_done, dbg_done}, {k == 2 || k == 5 || k == 8, k == 11});
         end
         if (k == 7 || k == 10) begin
            checks++;
            if (ram_addr !== (k == 7 ? 32'h10 : 32'h20)) begin errors++; $display("FAIL contention_addr[%0d]: got %h expected %h", k, ram_addr, k == 7 ? 32'h10 : 32'h20); end
         end
         if (k == 11) begin
            checks++;
            if (rdata !== 32'h12345678) begin errors++; $display("FAIL contention_dbg_data: got %h expected 12345678", rdata); end
         end
         if (k == 12) begin cpu_req = 1'b0; dbg_req = 1'b0; end
      end
   endtask

   task automatic test_latency3;
      l3_cpu_we = 1'b0; l3_cpu_addr = 32'h10; l3_cpu_req = 1'b1;
      l3_dbg_we = 1'b0; l3_dbg_addr = 32'h20;
      for (int k = 1; k <= 10; k++) begin
         cyc;
         checks++;
         if ({l3_cpu_done, l3_dbg_done} !== {k == 4, k == 9}) begin
            errors++; $display("FAIL lat3_done[%0d]: got %b expected %b", k, {l3_cpu_done, l3_dbg_done}, {k == 4, k == 9});
         end
         checks++;
         if (l3_ram_we !== 1'b0) begin errors++; $display("FAIL lat3_we[%0d]: got %b expected 0", k, l3_ram_we); end
         if (k == 4 || k == 9) begin
            checks++;
            if (l3_rdata !== (k == 4 ? 32'hDEADBEEF : 32'h12345678)) begin errors++; $display("FAIL lat3_data[%0d]: got %h expected %h", k, l3_rdata, k == 4 ? 32'hDEADBEEF : 32'h12345678); end
         end
         if (k == 6) begin
            checks++;
            if (l3_ram_addr !== 32'h20) begin errors++; $display("FAIL lat3_dbg_addr: got %h expected 00000020", l3_ram_addr); end
         end
         if (k == 2) l3_dbg_req = 1'b1;
         if (k == 5) l3_cpu_req = 1'b0;
         if (k == 10) l3_dbg_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5; cpu_req = 1'b1;
      cyc;
      checks++;
      if (ram_we !== 1'b1) begin errors++; $display("FAIL rstmid_we_before: got %b expected 1", ram_we); end
      reset = 1'b0;
      cyc;
      checks++;
      if ({ram_we, cpu_done, dbg_done, cpu_stall} !== 4'b0001) begin errors++; $display("FAIL rstmid_abort: got %b expected 0001", {ram_we, cpu_done, dbg_done, cpu_stall}); end
      cyc;
      checks++;
      if ({ram_we, cpu_done, dbg_done} !== 3'b000) begin errors++; $display("FAIL rstmid_hold: got %b expected 000", {ram_we, cpu_done, dbg_done}); end
      reset = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc;
         checks++;
         if ({ram_we, cpu_done} !== {k == 1, k == 2}) begin errors++; $display("FAIL rstmid_after[%0d]: got %b expected %b", k, {ram_we, cpu_done}, {k == 1, k == 2}); end
         if (k == 1) begin
            checks++;
            if (ram_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rstmid_wdata: got %h expected a5a5a5a5", ram_wdata); end
         end
         if (k == 3) cpu_req = 1'b0;
      end
   endtask

   task automatic test_back_to_back;
      dbg_we = 1'b0; dbg_addr = 32'h20; dbg_req = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         cyc;
         checks++;
         if ({cpu_done, dbg_done} !== {1'b0, k == 2 || k == 5}) begin
            errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, {cpu_done, dbg_done}, {1'b0, k == 2 || k == 5});
         end
         checks++;
         if (ram_addr !== 32'h20) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected 00000020", k, ram_addr); end
         if (k == 5) begin
            checks++;
            if (rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_data: got %h expected 12345678", rdata); end
         end
         if (k == 1) begin cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1; end
         if (k == 2) cpu_req = 1'b0;
         if (k == 6) dbg_req = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      mem[8'h10] = 32'hDEADBEEF;
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      l3_cpu_req = 1'b0; l3_cpu_we = 1'b0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
      l3_dbg_req = 1'b0; l3_dbg_we = 1'b0; l3_dbg_addr = '0; l3_dbg_wdata = '0;
      cyc;
      test_reset;
      test_cpu_read;
      test_dbg_write;
      test_contention;
      test_latency3;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
